// File: rtl/clock_pkg.sv
// Shared types and default constants for the clock adjust controller.
package clock_pkg;

  typedef enum logic {
    NORM = 1'b0,
    EDIT = 1'b1
  } state_t;

  localparam int unsigned NFIELD_DEF        = 3;
  localparam int unsigned TIMEOUT_TICKS_DEF = 30;
  localparam int unsigned REPEAT_DLY_DEF    = 2;

endpackage

// File: rtl/tick_counter.sv
// Saturating event counter: clr has priority, en advances the count until it
// holds at MAX; done_c is high while the count sits at MAX.
module tick_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // Count enabled events, stop at MAX, never wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign done_c = (cnt == W'(MAX));

endmodule

// File: rtl/clock_adjust_ctrl.sv
// Time-setting controller: MODE toggles edit mode, SELECT walks the edited
// field downward, ADJUST (+DOWN) pulses INC/DEC for the selected field, the
// selected field blinks at 2 Hz, and idle edit mode times out back to NORM.
// Optional auto-repeat on a held adjust button: define CLOCK_ADJ_AUTOREPEAT_EN.
module clock_adjust_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned NFIELD        = NFIELD_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int unsigned REPEAT_DLY    = REPEAT_DLY_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      SIG2HZ,
  input  logic                      MODE,
  input  logic                      SELECT,
  input  logic                      ADJUST,
  input  logic                      DOWN,
  input  logic                      ADJ_HELD,
  output logic [NFIELD-1:0]         INC,
  output logic [NFIELD-1:0]         DEC,
  output logic [NFIELD-1:0]         ON,
  output logic                      EDIT,
  output logic [$clog2(NFIELD)-1:0] SEL
);

  localparam int unsigned SW = $clog2(NFIELD);

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          sig_q;
  logic          rise;
  logic          in_edit;
  logic          to_clr, to_done_c;
  logic          rep_pulse;
  logic          adj_evt;

  assign rise    = SIG2HZ & ~sig_q;
  assign in_edit = (state_q == clock_pkg::EDIT);

  // Inactivity timer: held at zero outside edit mode and by any button activity.
  assign to_clr = ~in_edit | MODE | SELECT | ADJUST | ADJ_HELD;

  tick_counter #(
    .MAX (TIMEOUT_TICKS)
  ) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (to_clr),
    .en     (rise),
    .done_c (to_done_c)
  );

`ifdef CLOCK_ADJ_AUTOREPEAT_EN
  logic rep_clr, rep_done_c;

  // Repeat delay: counts 2 Hz edges while adjust is held in edit mode.
  assign rep_clr = ~in_edit | ~ADJ_HELD | SELECT | MODE;

  tick_counter #(
    .MAX (REPEAT_DLY)
  ) u_repeat (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (rep_clr),
    .en     (rise),
    .done_c (rep_done_c)
  );

  assign rep_pulse = in_edit & ADJ_HELD & rep_done_c & rise;
`else
  logic unused_repeat_dly;

  assign unused_repeat_dly = |REPEAT_DLY;
  assign rep_pulse         = 1'b0;
`endif

  // A repeat edge and a manual ADJUST in the same cycle merge into one pulse.
  assign adj_evt = ADJUST | rep_pulse;

  // State, field index and 2 Hz edge-detect registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= clock_pkg::NORM;
      sel_q   <= '0;
      sig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sig_q   <= SIG2HZ;
    end
  end

  // Next state: MODE beats SELECT beats ADJUST; timeout loses to any activity.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      clock_pkg::NORM: begin
        if (MODE) begin
          state_d = clock_pkg::EDIT;
          sel_d   = '0;
        end
      end
      clock_pkg::EDIT: begin
        if (MODE) begin
          state_d = clock_pkg::NORM;
          sel_d   = '0;
        end else if (SELECT) begin
          sel_d = (sel_q == '0) ? SW'(NFIELD - 1) : (sel_q - SW'(1));
        end else if (to_done_c && !ADJUST && !ADJ_HELD) begin
          state_d = clock_pkg::NORM;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = clock_pkg::NORM;
        sel_d   = '0;
      end
    endcase
  end

  // Same-cycle adjust pulses and per-field blink enables.
  always_comb begin
    INC = '0;
    DEC = '0;
    ON  = '1;
    if (!RST && in_edit && adj_evt && !MODE && !SELECT) begin
      if (DOWN) begin
        DEC = NFIELD'(1) << sel_q;
      end else begin
        INC = NFIELD'(1) << sel_q;
      end
    end
    for (int i = 0; i < int'(NFIELD); i++) begin
      if (in_edit && (sel_q == SW'(i)) && SIG2HZ) begin
        ON[i] = 1'b0;
      end
    end
  end

  assign EDIT = in_edit;
  assign SEL  = in_edit ? sel_q : '0;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Directed bench for clock_adjust_ctrl with NFIELD=3, TIMEOUT_TICKS=4,
// REPEAT_DLY=2. Auto-repeat expectations follow CLOCK_ADJ_AUTOREPEAT_EN.
module tb_clock_adjust_ctrl;

  logic       CLK;
  logic       RST;
  logic       SIG2HZ;
  logic       MODE;
  logic       SELECT;
  logic       ADJUST;
  logic       DOWN;
  logic       ADJ_HELD;
  logic [2:0] INC;
  logic [2:0] DEC;
  logic [2:0] ON;
  logic       EDIT;
  logic [1:0] SEL;

  int checks = 0;
  int errors = 0;
  int pulses;
  int stray;
  int exp_pulses;

  clock_adjust_ctrl #(
    .NFIELD        (3),
    .TIMEOUT_TICKS (4),
    .REPEAT_DLY    (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SIG2HZ   (SIG2HZ),
    .MODE     (MODE),
    .SELECT   (SELECT),
    .ADJUST   (ADJUST),
    .DOWN     (DOWN),
    .ADJ_HELD (ADJ_HELD),
    .INC      (INC),
    .DEC      (DEC),
    .ON       (ON),
    .EDIT     (EDIT),
    .SEL      (SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One 2 Hz period: high for one cycle, low for one cycle.
  task automatic pulse_2hz();
    SIG2HZ = 1'b1;
    tick();
    SIG2HZ = 1'b0;
    tick();
  endtask

  task automatic press_mode();
    MODE = 1'b1;
    tick();
    MODE = 1'b0;
  endtask

  task automatic press_select();
    SELECT = 1'b1;
    tick();
    SELECT = 1'b0;
  endtask

  initial begin
`ifdef CLOCK_ADJ_AUTOREPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 0;
`endif
    RST = 1'b1; SIG2HZ = 1'b0; MODE = 1'b0; SELECT = 1'b0;
    ADJUST = 1'b0; DOWN = 1'b0; ADJ_HELD = 1'b0;

    // Reset state
    #2;
    chk("rst_edit", 8'(EDIT), 8'h0);
    chk("rst_sel",  8'(SEL),  8'h0);
    chk("rst_on",   8'(ON),   8'h7);
    chk("rst_inc",  8'(INC),  8'h0);
    chk("rst_dec",  8'(DEC),  8'h0);
    tick(); tick();
    RST = 1'b0;
    tick();

    // Enter edit mode; MODE in NORM gives no pulse
    MODE = 1'b1; ADJUST = 1'b1; #1;
    chk("norm_mode_inc", 8'(INC), 8'h0);
    tick();
    MODE = 1'b0; ADJUST = 1'b0; #1;
    chk("enter_edit", 8'(EDIT), 8'h1);
    chk("enter_sel",  8'(SEL),  8'h0);

    // Blink of field 0
    SIG2HZ = 1'b1; #1;
    chk("on_sel0_hi", 8'(ON), 8'h6);
    tick();
    SIG2HZ = 1'b0; #1;
    chk("on_sel0_lo", 8'(ON), 8'h7);

    // SELECT walks 0 -> 2
    press_select(); #1;
    chk("sel_2", 8'(SEL), 8'h2);

    // ADJUST at field 2, up then down
    ADJUST = 1'b1; #1;
    chk("inc_f2", 8'(INC), 8'h4);
    chk("inc_f2_dec", 8'(DEC), 8'h0);
    tick();
    ADJUST = 1'b0; #1;
    chk("inc_f2_one_cycle", 8'(INC), 8'h0);
    ADJUST = 1'b1; DOWN = 1'b1; #1;
    chk("dec_f2", 8'(DEC), 8'h4);
    chk("dec_f2_inc", 8'(INC), 8'h0);
    tick();
    ADJUST = 1'b0; DOWN = 1'b0;

    // SELECT walks 2 -> 1 -> 0
    press_select(); #1;
    chk("sel_1", 8'(SEL), 8'h1);
    press_select(); #1;
    chk("sel_0", 8'(SEL), 8'h0);

    // MODE + SELECT + ADJUST together: exit, no pulse
    MODE = 1'b1; SELECT = 1'b1; ADJUST = 1'b1; #1;
    chk("prio_inc", 8'(INC), 8'h0);
    chk("prio_dec", 8'(DEC), 8'h0);
    tick();
    MODE = 1'b0; SELECT = 1'b0; ADJUST = 1'b0; #1;
    chk("prio_exit_edit", 8'(EDIT), 8'h0);
    chk("prio_exit_sel",  8'(SEL),  8'h0);

    // NORM ignores SIG2HZ for ON and ADJUST for INC
    SIG2HZ = 1'b1; ADJUST = 1'b1; #1;
    chk("norm_on",  8'(ON),  8'h7);
    chk("norm_inc", 8'(INC), 8'h0);
    tick();
    SIG2HZ = 1'b0; ADJUST = 1'b0;
    tick();

    // Timeout after the 4th 2 Hz edge with no activity
    press_mode();
    repeat (3) pulse_2hz();
    chk("to_edit_after3", 8'(EDIT), 8'h1);
    SIG2HZ = 1'b1;
    tick();
    SIG2HZ = 1'b0;
    tick();
    chk("to_norm_after4", 8'(EDIT), 8'h0);
    chk("to_sel_cleared", 8'(SEL),  8'h0);

    // ADJUST on the 4th edge wins over the timeout
    press_mode();
    repeat (3) pulse_2hz();
    SIG2HZ = 1'b1; ADJUST = 1'b1; #1;
    chk("race_inc", 8'(INC), 8'h1);
    tick();
    SIG2HZ = 1'b0; ADJUST = 1'b0;
    tick(); tick(); tick();
    chk("race_keeps_edit", 8'(EDIT), 8'h1);
    press_mode(); #1;
    chk("race_exit", 8'(EDIT), 8'h0);

    // Held adjust at field 1 for six 2 Hz edges
    press_mode();
    press_select();
    press_select(); #1;
    chk("rep_sel_1", 8'(SEL), 8'h1);
    ADJ_HELD = 1'b1;
    pulses = 0;
    stray  = 0;
    for (int e = 0; e < 6; e++) begin
      SIG2HZ = 1'b1; #1;
      if (INC == 3'b010) pulses++;
      else if (INC != 3'b000) stray++;
      if (DEC != 3'b000) stray++;
      tick();
      SIG2HZ = 1'b0; #1;
      if (INC != 3'b000 || DEC != 3'b000) stray++;
      tick();
    end
    chk("rep_pulses", 8'(pulses), 8'(exp_pulses));
    chk("rep_stray",  8'(stray),  8'h0);
    chk("rep_edit",   8'(EDIT),   8'h1);
    ADJ_HELD = 1'b0;

    // Asynchronous reset mid-edit, observed before any clock edge
    ADJUST = 1'b1; SIG2HZ = 1'b1; RST = 1'b1; #1;
    chk("arst_edit", 8'(EDIT), 8'h0);
    chk("arst_sel",  8'(SEL),  8'h0);
    chk("arst_on",   8'(ON),   8'h7);
    chk("arst_inc",  8'(INC),  8'h0);
    chk("arst_dec",  8'(DEC),  8'h0);
    tick();
    RST = 1'b0; ADJUST = 1'b0; SIG2HZ = 1'b0;
    tick();
    chk("post_rst_edit", 8'(EDIT), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
